// File: rtl/riscv_pkg.sv
// Shared core definitions, with the load/store unit additions.
//   XLEN               : data/address width of the core.
//   LSU_F3_*           : RV32I funct3 size/sign encodings for loads and stores.
//   lsu_state_t        : load/store unit FSM states.
//   lsu_byte_en()      : store funct3 -> low-aligned 4-bit byte-enable mask.
//   lsu_f3_legal()     : whether a funct3 is a valid load or store encoding.
//   lsu_misaligned()   : natural-alignment check for a funct3 and address LSBs.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] LSU_F3_B  = 3'b000;
    localparam logic [2:0] LSU_F3_H  = 3'b001;
    localparam logic [2:0] LSU_F3_W  = 3'b010;
    localparam logic [2:0] LSU_F3_BU = 3'b100;
    localparam logic [2:0] LSU_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ISSUE,
        LSU_RESP
    } lsu_state_t;

    function automatic logic [3:0] lsu_byte_en(input logic [2:0] funct3);
        logic [3:0] mask;
        case (funct3)
            LSU_F3_B: mask = 4'b0001;
            LSU_F3_H: mask = 4'b0011;
            LSU_F3_W: mask = 4'b1111;
            default:  mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic lsu_f3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we) begin
            ok = (funct3 == LSU_F3_B) || (funct3 == LSU_F3_H) || (funct3 == LSU_F3_W);
        end else begin
            ok = (funct3 == LSU_F3_B)  || (funct3 == LSU_F3_H) || (funct3 == LSU_F3_W) ||
                 (funct3 == LSU_F3_BU) || (funct3 == LSU_F3_HU);
        end
        return ok;
    endfunction

    // Size lives in funct3[1:0] for both loads and stores, so the signedness
    // bit does not matter here.
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extension: selects and sign/zero-extends the low bytes of a raw
// memory word according to the RV32I load funct3.
//   funct3 : load size/sign encoding (LB/LH/LW/LBU/LHU); others give 0.
//   raw    : word from memory, addressed byte in [7:0].
//   result : extended XLEN-bit load value.
module load_extend #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] result
);
    import riscv_pkg::*;

    always_comb begin
        result = '0;
        case (funct3)
            LSU_F3_B:  result = {{(XLEN-8){raw[7]}}, raw[7:0]};
            LSU_F3_H:  result = {{(XLEN-16){raw[15]}}, raw[15:0]};
            LSU_F3_W:  result = raw;
            LSU_F3_BU: result = {{(XLEN-8){1'b0}}, raw[7:0]};
            LSU_F3_HU: result = {{(XLEN-16){1'b0}}, raw[15:0]};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the core's data-memory port. Accepts one
// load/store per req handshake, issues it to memory for exactly one cycle and
// returns a tagged, extended response through a valid/ready handshake.
// Only one request is in flight at a time (IDLE -> ISSUE -> RESP).
//   req_*    : request from the MEM stage (we, funct3, addr, wdata, tag).
//   resp_*   : response (rdata, tag, fault) held stable until resp_ready.
//   dmem_*   : byte address, low-aligned write data, byte enables, rd/wr
//              strobes; dmem_rdata is combinational from the memory.
// Build option: define LSU_MISALIGN_TRAP_EN to fault naturally-misaligned
// halfword/word accesses instead of issuing them.
module load_store_unit #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_rdata,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_fault,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic [3:0]       dmem_byte_en,
    output logic             dmem_wr_en,
    output logic             dmem_rd_en,
    input  logic [XLEN-1:0]  dmem_rdata
);
    import riscv_pkg::*;

    lsu_state_t       state_reg, state_next;
    logic             we_reg;
    logic [2:0]       funct3_reg;
    logic [XLEN-1:0]  addr_reg;
    logic [XLEN-1:0]  wdata_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [XLEN-1:0]  rdata_reg;
    logic             fault_reg;
    logic             accept;
    logic             req_fault;
    logic [XLEN-1:0]  ext_data;

    // Faults are decided from the raw request so a faulting access can skip
    // ISSUE and never touch memory.
`ifdef LSU_MISALIGN_TRAP_EN
    assign req_fault = !lsu_f3_legal(req_we, req_funct3) ||
                       lsu_misaligned(req_funct3, req_addr[1:0]);
`else
    assign req_fault = !lsu_f3_legal(req_we, req_funct3);
`endif

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3 (funct3_reg),
        .raw    (dmem_rdata),
        .result (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= LSU_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Strobes are masked by reset so a reset landing on ISSUE cannot commit
    // a write at that same edge.
    always_comb begin
        state_next   = state_reg;
        accept       = 1'b0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        dmem_rd_en   = 1'b0;
        dmem_wr_en   = 1'b0;
        dmem_byte_en = 4'b0000;
        case (state_reg)
            LSU_IDLE: begin
                req_ready = !reset;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = req_fault ? LSU_RESP : LSU_ISSUE;
                end
            end
            LSU_ISSUE: begin
                dmem_rd_en   = !we_reg && !reset;
                dmem_wr_en   = we_reg && !reset;
                dmem_byte_en = (we_reg && !reset) ? lsu_byte_en(funct3_reg) : 4'b0000;
                state_next   = LSU_RESP;
            end
            LSU_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = LSU_IDLE;
                end
            end
            default: state_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            tag_reg    <= '0;
            rdata_reg  <= '0;
            fault_reg  <= 1'b0;
        end else begin
            if (accept) begin
                we_reg     <= req_we;
                funct3_reg <= req_funct3;
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
                tag_reg    <= req_tag;
                fault_reg  <= req_fault;
                // Stores and faults report zero data.
                rdata_reg  <= '0;
            end
            if ((state_reg == LSU_ISSUE) && !we_reg) begin
                rdata_reg <= ext_data;
            end
        end
    end

    assign resp_rdata = rdata_reg;
    assign resp_tag   = tag_reg;
    assign resp_fault = fault_reg;
    assign dmem_addr  = addr_reg;
    assign dmem_wdata = wdata_reg;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the core's data-memory port: accepts one load/store per handshake from the MEM stage.
- Drives memory_controller-style dmem signals: byte address, low-aligned write data, 4-bit byte enable, rd/wr strobes, combinational read data.
- Sign/zero-extends load data, optionally traps misaligned accesses, and returns a tagged response through a valid/ready handshake.
- One request in flight; three-state FSM.

Parameters:
- XLEN, riscv_pkg::XLEN (32), data/address width.
- TAG_W, 5, destination-register tag width carried from request to response.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size/sign encoding.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data (rs2, unshifted).
- req_tag  in  TAG_W  rd tag.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- resp_tag  out  TAG_W  echoed tag.
- resp_fault  out  1  illegal funct3 or (optional) misalignment.
- dmem_addr  out  XLEN  byte address to memory.
- dmem_wdata  out  XLEN  write data, byte i on bits [8i+7:8i].
- dmem_byte_en  out  4  write byte enables.
- dmem_wr_en  out  1  write strobe; memory commits at posedge.
- dmem_rd_en  out  1  read strobe.
- dmem_rdata  in  XLEN  combinational read data, byte at dmem_addr in [7:0].

Behaviour:
- Reset: state IDLE, req_ready=0 during the reset cycle, resp_valid=0, resp_fault=0, resp_rdata=0, resp_tag=0, all dmem_* outputs 0.
- Reset wins over every other event in any state; in-flight work is dropped.
- dmem_wr_en is gated with !reset, so no memory write occurs on a reset cycle even in ISSUE.
- IDLE:
  - req_ready=1.
  - On req_valid: register we/funct3/addr/wdata/tag and decode.
  - Illegal encoding or trap → RESP with fault=1, no memory access.
  - Otherwise → ISSUE.
- ISSUE (exactly 1 cycle, req_ready=0):
  - dmem_addr=addr_q.
  - Load: dmem_rd_en=1, byte_en=0000; capture extended dmem_rdata into resp_rdata at cycle end.
  - Store: dmem_wr_en=1, dmem_wdata=wdata_q, byte_en = SB 0001, SH 0011, SW 1111; resp_rdata=0.
  - → RESP.
- RESP:
  - resp_valid=1; resp_rdata/resp_tag/resp_fault held stable until resp_ready.
  - On resp_ready → IDLE; resp_valid drops next cycle.
- Outside ISSUE: dmem_rd_en=0, dmem_wr_en=0, dmem_byte_en=0; dmem_addr/dmem_wdata hold registered values.
- Latency: request accepted at edge N, ISSUE in cycle N+1, resp_valid from cycle N+2. Minimum issue interval is 3 cycles.
- Load extension, funct3:
  - LB (000): sign-extend [7:0].
  - LH (001): sign-extend [15:0].
  - LW (010): full word.
  - LBU (100): zero-extend [7:0].
  - LHU (101): zero-extend [15:0].
  - Loads 011/110/111 are illegal.
- Store funct3: 000/001/010 are legal; all others are illegal.
- Faulting loads return rdata=0.
- Out-of-range addresses are not detected here; the memory returns 0 and ignores writes.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0, go directly IDLE→RESP with resp_fault=1 and no dmem strobe.
- Undefined: misaligned accesses are issued unchanged (memory is byte-addressed), and resp_fault reflects only illegal funct3.

Decomposition:
- riscv_pkg additions:
  - localparams LSU_F3_B/H/W/BU/HU.
  - typedef enum logic [1:0] lsu_state_t {LSU_IDLE, LSU_ISSUE, LSU_RESP}.
  - function lsu_byte_en(funct3) returning 4-bit mask.
- Sub-module load_extend: combinational funct3 + raw word → extended XLEN result, instanced once and unit-testable.

Test Plan:
- LW addr 0x10, memory word 0x8000_00F1 → resp at cycle N+2, rdata 0x8000_00F1, fault 0, tag echoed.
- SB addr 0x21 wdata 0xAABB_CCDD → single ISSUE cycle with byte_en 0001, wr_en 1; then LBU 0x21 → 0x0000_00DD and LB 0x21 → 0xFFFF_FFDD.
- SH 0x40 wdata 0x0000_8001 then LH 0x40 → 0xFFFF_8001, LHU 0x40 → 0x0000_8001.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid and data stable, req_ready=0, no dmem strobes; release → IDLE next cycle.
- Load funct3=011 → fault=1, rdata 0, dmem_rd_en never asserted.
- LW addr 0x13: with LSU_MISALIGN_TRAP_EN → fault, no strobe; without → issued, fault 0.
- Assert reset during ISSUE of SW → memory word unchanged, state IDLE, resp_valid 0.
